// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the hardwired control sequencer.
// Opcode map, ALU operation codes, DataPath bus bit indices, the
// sequencer state enum and the instruction-class decode helpers.
package ctrl_pkg;

    localparam int NREG  = 16;
    localparam int ALU_W = 16;
    localparam int BUS_W = 32;
    localparam int OP_W  = 5;

    // Opcodes (ir[31:27])
    localparam logic [OP_W-1:0] OP_LD   = 5'd0;
    localparam logic [OP_W-1:0] OP_ST   = 5'd2;
    localparam logic [OP_W-1:0] OP_ADD  = 5'd3;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd4;
    localparam logic [OP_W-1:0] OP_AND  = 5'd5;
    localparam logic [OP_W-1:0] OP_OR   = 5'd6;
    localparam logic [OP_W-1:0] OP_SHR  = 5'd7;
    localparam logic [OP_W-1:0] OP_SHL  = 5'd8;
    localparam logic [OP_W-1:0] OP_ROR  = 5'd9;
    localparam logic [OP_W-1:0] OP_ROL  = 5'd10;
    localparam logic [OP_W-1:0] OP_ADDI = 5'd12;
    localparam logic [OP_W-1:0] OP_ANDI = 5'd13;
    localparam logic [OP_W-1:0] OP_ORI  = 5'd14;
    localparam logic [OP_W-1:0] OP_BR   = 5'd18;
    localparam logic [OP_W-1:0] OP_JR   = 5'd19;
    localparam logic [OP_W-1:0] OP_NOP  = 5'd26;
    localparam logic [OP_W-1:0] OP_HALT = 5'd27;

    // ALU operation codes
    localparam logic [ALU_W-1:0] ALU_NONE  = 16'd0;
    localparam logic [ALU_W-1:0] ALU_ADD   = 16'd1;
    localparam logic [ALU_W-1:0] ALU_SUB   = 16'd2;
    localparam logic [ALU_W-1:0] ALU_AND   = 16'd3;
    localparam logic [ALU_W-1:0] ALU_OR    = 16'd4;
    localparam logic [ALU_W-1:0] ALU_SHR   = 16'd10;
    localparam logic [ALU_W-1:0] ALU_SHL   = 16'd11;
    localparam logic [ALU_W-1:0] ALU_ROR   = 16'd12;
    localparam logic [ALU_W-1:0] ALU_ROL   = 16'd13;
    localparam logic [ALU_W-1:0] ALU_INCPC = 16'd15;

    // Bus bit indices shared with DataPath (bits 15:0 are R0..R15)
    localparam int BUS_ZLO = 19;
    localparam int BUS_PC  = 20;
    localparam int BUS_MDR = 21;
    localparam int BUS_C   = 23;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_T7,
        ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_RR,
        CL_IMM,
        CL_LD,
        CL_ST,
        CL_JR,
        CL_BR,
        CL_NOP,
        CL_HALT,
        CL_ILL
    } iclass_t;

    // Map an opcode onto the execute sequence it uses; br is only a real
    // instruction when the branch feature is built in.
    function automatic iclass_t decode_class(input logic [OP_W-1:0] op,
                                             input logic br_en);
        iclass_t c;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: c = CL_RR;
            OP_ADDI, OP_ANDI, OP_ORI:       c = CL_IMM;
            OP_LD:                          c = CL_LD;
            OP_ST:                          c = CL_ST;
            OP_JR:                          c = CL_JR;
            OP_NOP:                         c = CL_NOP;
            OP_HALT:                        c = CL_HALT;
            OP_BR: begin
                if (br_en) begin
                    c = CL_BR;
                end else begin
                    c = CL_ILL;
                end
            end
            default:                        c = CL_ILL;
        endcase
        return c;
    endfunction

    // ALU code driven in the compute step; address arithmetic uses add.
    function automatic logic [ALU_W-1:0] alu_code(input logic [OP_W-1:0] op);
        logic [ALU_W-1:0] a;
        case (op)
            OP_ADD, OP_ADDI, OP_LD, OP_ST: a = ALU_ADD;
            OP_SUB:                        a = ALU_SUB;
            OP_AND, OP_ANDI:               a = ALU_AND;
            OP_OR, OP_ORI:                 a = ALU_OR;
            OP_SHR:                        a = ALU_SHR;
            OP_SHL:                        a = ALU_SHL;
            OP_ROR:                        a = ALU_ROR;
            OP_ROL:                        a = ALU_ROL;
            default:                       a = ALU_NONE;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/reg_select.sv
// reg_select: 4-bit register field to one-hot register-slice enable.
module reg_select #(
    parameter int NREG  = 16,
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0] field,
    input  logic             en,
    output logic [NREG-1:0]  onehot
);

    // One bit per general register; field 0 selects R0 like any other.
    always_comb begin
        onehot = {NREG{1'b0}};
        if (en) begin
            onehot[field] = 1'b1;
        end else begin
            onehot = {NREG{1'b0}};
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: hardwired fetch/decode/execute control unit for DataPath.
// Walks T0..T7 per instruction with a memory-ready handshake in the two
// memory steps and drives the DataPath strobe bundle from the state and ir.
// Build option: define CTRL_BRANCH_EN to execute br; otherwise br decodes
// as an undefined opcode (illegal pulse, then behaves as nop).
module ctrl_sequencer
    import ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic [31:0]       ir,
    input  logic              mem_ready,
    input  logic              con_ff,
    output logic [BUS_W-1:0]  Rin,
    output logic [BUS_W-1:0]  Rout,
    output logic [ALU_W-1:0]  ALUControl,
    output logic              IRin,
    output logic              MARin,
    output logic              RYin,
    output logic              MDRread,
    output logic              PCjump,
    output logic              mem_read,
    output logic              mem_write,
    output logic              run,
    output logic              illegal
);

`ifdef CTRL_BRANCH_EN
    localparam logic BR_EN = 1'b1;
`else
    localparam logic BR_EN = 1'b0;
`endif

    state_t            state_r;
    iclass_t           class_s;
    logic [OP_W-1:0]   opcode_s;
    logic [3:0]        ra_s;
    logic [3:0]        rb_s;
    logic [3:0]        rc_s;
    logic [ALU_W-1:0]  alu_op_s;

    logic [BUS_W-1:0]  rin_misc_s;
    logic [BUS_W-1:0]  rout_misc_s;
    logic              rin_reg_en_s;
    logic              rout_reg_en_s;
    logic [3:0]        rout_field_s;
    logic [NREG-1:0]   rin_reg_s;
    logic [NREG-1:0]   rout_reg_s;
    logic [ALU_W-1:0]  alu_s;
    logic              irin_s;
    logic              marin_s;
    logic              ryin_s;
    logic              mdrread_s;
    logic              pcjump_s;
    logic              mem_read_s;
    logic              mem_write_s;
    logic              illegal_s;
    logic              imm_unused_s;

    assign opcode_s     = ir[31:27];
    assign ra_s         = ir[26:23];
    assign rb_s         = ir[22:19];
    assign rc_s         = ir[18:15];
    assign class_s      = decode_class(opcode_s, BR_EN);
    assign alu_op_s     = alu_code(opcode_s);
    // Low immediate bits belong to DataPath's Cout path, not to control.
    assign imm_unused_s = ^ir[14:0];

    reg_select #(.NREG(NREG), .SEL_W(4)) u_rin_sel (
        .field  (ra_s),
        .en     (rin_reg_en_s),
        .onehot (rin_reg_s)
    );

    reg_select #(.NREG(NREG), .SEL_W(4)) u_rout_sel (
        .field  (rout_field_s),
        .en     (rout_reg_en_s),
        .onehot (rout_reg_s)
    );

    // Sequencer state: fetch T0-T2, class-specific execute steps, memory
    // waits held in T1/T6/T7, halt is sticky until clear.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r <= ST_RESET;
        end else begin
            case (state_r)
                ST_RESET: state_r <= ST_T0;
                ST_T0:    state_r <= ST_T1;
                ST_T1: begin
                    if (mem_ready) begin
                        state_r <= ST_T2;
                    end else begin
                        state_r <= ST_T1;
                    end
                end
                ST_T2: begin
                    case (class_s)
                        CL_NOP, CL_ILL: state_r <= ST_T0;
                        CL_HALT:        state_r <= ST_HALT;
                        default:        state_r <= ST_T3;
                    endcase
                end
                ST_T3: begin
                    case (class_s)
                        CL_RR, CL_IMM, CL_LD, CL_ST, CL_BR: state_r <= ST_T4;
                        default:                            state_r <= ST_T0;
                    endcase
                end
                ST_T4: state_r <= ST_T5;
                ST_T5: begin
                    case (class_s)
                        CL_LD, CL_ST, CL_BR: state_r <= ST_T6;
                        default:             state_r <= ST_T0;
                    endcase
                end
                ST_T6: begin
                    case (class_s)
                        CL_LD: begin
                            if (mem_ready) begin
                                state_r <= ST_T7;
                            end else begin
                                state_r <= ST_T6;
                            end
                        end
                        CL_ST:   state_r <= ST_T7;
                        default: state_r <= ST_T0;
                    endcase
                end
                ST_T7: begin
                    if ((class_s == CL_ST) && !mem_ready) begin
                        state_r <= ST_T7;
                    end else begin
                        state_r <= ST_T0;
                    end
                end
                ST_HALT: state_r <= ST_HALT;
                default: state_r <= ST_RESET;
            endcase
        end
    end

    // Control bundle decode for the current step; RESET and HALT drive nothing.
    always_comb begin
        rin_misc_s    = 32'h0000_0000;
        rout_misc_s   = 32'h0000_0000;
        rin_reg_en_s  = 1'b0;
        rout_reg_en_s = 1'b0;
        rout_field_s  = 4'd0;
        alu_s         = ALU_NONE;
        irin_s        = 1'b0;
        marin_s       = 1'b0;
        ryin_s        = 1'b0;
        mdrread_s     = 1'b0;
        pcjump_s      = 1'b0;
        mem_read_s    = 1'b0;
        mem_write_s   = 1'b0;
        illegal_s     = 1'b0;
        case (state_r)
            ST_T0: begin
                rout_misc_s[BUS_PC]  = 1'b1;
                marin_s              = 1'b1;
                alu_s                = ALU_INCPC;
                rin_misc_s[BUS_ZLO]  = 1'b1;
            end
            ST_T1: begin
                rout_misc_s[BUS_ZLO] = 1'b1;
                rin_misc_s[BUS_MDR]  = 1'b1;
                mdrread_s            = 1'b1;
                mem_read_s           = 1'b1;
                // PC takes the increment only once the fetch completes.
                if (mem_ready) begin
                    rin_misc_s[BUS_PC] = 1'b1;
                end else begin
                    rin_misc_s[BUS_PC] = 1'b0;
                end
            end
            ST_T2: begin
                rout_misc_s[BUS_MDR] = 1'b1;
                irin_s               = 1'b1;
                if (class_s == CL_ILL) begin
                    illegal_s = 1'b1;
                end else begin
                    illegal_s = 1'b0;
                end
            end
            ST_T3: begin
                case (class_s)
                    CL_RR, CL_IMM, CL_LD, CL_ST: begin
                        rout_field_s  = rb_s;
                        rout_reg_en_s = 1'b1;
                        ryin_s        = 1'b1;
                    end
                    CL_JR: begin
                        rout_field_s       = ra_s;
                        rout_reg_en_s      = 1'b1;
                        rin_misc_s[BUS_PC] = 1'b1;
                        pcjump_s           = 1'b1;
                    end
                    CL_BR: begin
                        rout_field_s  = ra_s;
                        rout_reg_en_s = 1'b1;
                    end
                    default: begin
                        rout_reg_en_s = 1'b0;
                    end
                endcase
            end
            ST_T4: begin
                case (class_s)
                    CL_RR: begin
                        rout_field_s        = rc_s;
                        rout_reg_en_s       = 1'b1;
                        alu_s               = alu_op_s;
                        rin_misc_s[BUS_ZLO] = 1'b1;
                    end
                    CL_IMM, CL_LD, CL_ST: begin
                        rout_misc_s[BUS_C]  = 1'b1;
                        alu_s               = alu_op_s;
                        rin_misc_s[BUS_ZLO] = 1'b1;
                    end
                    CL_BR: begin
                        rout_misc_s[BUS_PC] = 1'b1;
                        ryin_s              = 1'b1;
                    end
                    default: begin
                        alu_s = ALU_NONE;
                    end
                endcase
            end
            ST_T5: begin
                case (class_s)
                    CL_RR, CL_IMM: begin
                        rout_misc_s[BUS_ZLO] = 1'b1;
                        rin_reg_en_s         = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        rout_misc_s[BUS_ZLO] = 1'b1;
                        marin_s              = 1'b1;
                    end
                    CL_BR: begin
                        rout_misc_s[BUS_C]  = 1'b1;
                        alu_s               = ALU_ADD;
                        rin_misc_s[BUS_ZLO] = 1'b1;
                    end
                    default: begin
                        rin_reg_en_s = 1'b0;
                    end
                endcase
            end
            ST_T6: begin
                case (class_s)
                    CL_LD: begin
                        mdrread_s           = 1'b1;
                        rin_misc_s[BUS_MDR] = 1'b1;
                        mem_read_s          = 1'b1;
                    end
                    CL_ST: begin
                        // Store data goes in through the bus side of MDR.
                        rout_field_s        = ra_s;
                        rout_reg_en_s       = 1'b1;
                        rin_misc_s[BUS_MDR] = 1'b1;
                        mdrread_s           = 1'b0;
                    end
                    CL_BR: begin
                        rout_misc_s[BUS_ZLO] = 1'b1;
                        if (con_ff) begin
                            rin_misc_s[BUS_PC] = 1'b1;
                        end else begin
                            rin_misc_s[BUS_PC] = 1'b0;
                        end
                    end
                    default: begin
                        mdrread_s = 1'b0;
                    end
                endcase
            end
            ST_T7: begin
                case (class_s)
                    CL_LD: begin
                        rout_misc_s[BUS_MDR] = 1'b1;
                        rin_reg_en_s         = 1'b1;
                    end
                    CL_ST: begin
                        mem_write_s = 1'b1;
                    end
                    default: begin
                        mem_write_s = 1'b0;
                    end
                endcase
            end
            default: begin
                illegal_s = 1'b0;
            end
        endcase
    end

    assign Rin        = rin_misc_s  | {{(BUS_W-NREG){1'b0}}, rin_reg_s};
    assign Rout       = rout_misc_s | {{(BUS_W-NREG){1'b0}}, rout_reg_s};
    assign ALUControl = alu_s;
    assign IRin       = irin_s;
    assign MARin      = marin_s;
    assign RYin       = ryin_s;
    assign MDRread    = mdrread_s;
    assign PCjump     = pcjump_s;
    assign mem_read   = mem_read_s;
    assign mem_write  = mem_write_s;
    assign illegal    = illegal_s;
    assign run        = (state_r != ST_HALT);

endmodule
